// File: rtl/mem_pkg.sv
// Shared definitions for the memory interface stage and the RAM it feeds.
package mem_pkg;

    // Default RAM geometry, shared with the RAM instance
    localparam int MEM_DEPTH = 9;
    localparam int MEM_WIDTH = 32;

    // Wait-state counter width (WAIT_STATES up to 15)
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ld_reg.sv
// Load-enabled register with asynchronous active-high clear; used for MAR and MDR.
module ld_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Hold value unless load is asserted; clear wins asynchronously
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            o_q <= '0;
        end else if (i_ld) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory interface stage: owns MAR/MDR, sequences RAM reads (with wait
// states) and single-cycle writes, and reports busy/done to the control unit.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WIDTH       = MEM_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             mar_in,
    input  logic             mdr_in,
    input  logic             read,
    input  logic             write,
    output logic [WIDTH-1:0] mdr_q,
    output logic [DEPTH-1:0] mar_q,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_w_data,
    output logic             ram_wr_en,
    input  logic [WIDTH-1:0] ram_r_data
);

    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy;
    logic             w_capture;
    logic             w_mar_ld;
    logic             w_mdr_ld;
    logic [WIDTH-1:0] w_mdr_d;

    // State register and wait-state counter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic plus outputs decoded from the current state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_busy      = 1'b1;
        done        = 1'b0;
        ram_wr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                // Write wins when both requests arrive together
                if (write) begin
                    w_state_nxt = WR;
                end else if (read) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = WS_INIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            WR: begin
                ram_wr_en   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Host loads are only honoured in IDLE so the RAM sees stable MAR/MDR
    assign w_mar_ld = mar_in & ~w_busy;
    assign w_mdr_ld = (mdr_in & ~w_busy) | w_capture;
    assign w_mdr_d  = w_capture ? ram_r_data : bus_in;

    ld_reg #(.WIDTH(DEPTH)) u_mar (
        .clk  (clk),
        .clr  (clr),
        .i_ld (w_mar_ld),
        .i_d  (bus_in[DEPTH-1:0]),
        .o_q  (mar_q)
    );

    ld_reg #(.WIDTH(WIDTH)) u_mdr (
        .clk  (clk),
        .clr  (clr),
        .i_ld (w_mdr_ld),
        .i_d  (w_mdr_d),
        .o_q  (mdr_q)
    );

    assign busy       = w_busy;
    assign ram_addr   = mar_q;
    assign ram_w_data = mdr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: main instance (WAIT_STATES=1) with a RAM
// model, plus two read-only instances for the wait-state sweep.
module tb_mem_ctrl;

    localparam logic [31:0] AUX0_DATA = 32'hCAFE_0000;
    localparam logic [31:0] AUX3_DATA = 32'hCAFE_0003;

    logic        clk;
    logic        clr;
    logic [31:0] bus_in;
    logic        mar_in;
    logic        mdr_in;
    logic        read;
    logic        write;
    logic [31:0] mdr_q;
    logic [8:0]  mar_q;
    logic        busy;
    logic        done;
    logic [8:0]  ram_addr;
    logic [31:0] ram_w_data;
    logic        ram_wr_en;
    logic [31:0] ram_r_data;

    logic        a0_read, a3_read;
    logic [31:0] a0_mdr, a3_mdr, a0_wd, a3_wd;
    logic [8:0]  a0_mar, a3_mar, a0_addr, a3_addr;
    logic        a0_busy, a3_busy, a0_done, a3_done, a0_we, a3_we;

    logic [31:0] mem [512];
    logic        wvalid [512];
    int          wr_cnt;
    logic [31:0] sb [$];
    int          total;
    int          bad;

    mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(1)) u_dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .read(read), .write(write), .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy),
        .done(done), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
        .ram_wr_en(ram_wr_en), .ram_r_data(ram_r_data)
    );

    mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .clr(clr), .bus_in(32'h0), .mar_in(1'b0), .mdr_in(1'b0),
        .read(a0_read), .write(1'b0), .mdr_q(a0_mdr), .mar_q(a0_mar), .busy(a0_busy),
        .done(a0_done), .ram_addr(a0_addr), .ram_w_data(a0_wd),
        .ram_wr_en(a0_we), .ram_r_data(AUX0_DATA)
    );

    mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .clr(clr), .bus_in(32'h0), .mar_in(1'b0), .mdr_in(1'b0),
        .read(a3_read), .write(1'b0), .mdr_q(a3_mdr), .mar_q(a3_mar), .busy(a3_busy),
        .done(a3_done), .ram_addr(a3_addr), .ram_w_data(a3_wd),
        .ram_wr_en(a3_we), .ram_r_data(AUX3_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [8:0] a);
        return {16'hA5A5, 7'd0, a};
    endfunction

    // RAM model: asynchronous read, write committed at the edge ending WR
    assign ram_r_data = wvalid[ram_addr] ? mem[ram_addr] : pat(ram_addr);

    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_addr]    <= ram_w_data;
            wvalid[ram_addr] <= 1'b1;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected MDR value
    always @(negedge clk) begin
        if (!clr && done) begin
            if (sb.size() == 0) check("done_unexpected", 32'd1, 32'd0);
            else                check("sb_mdr", mdr_q, sb.pop_front());
        end
    end

    task automatic load_mar(input logic [31:0] v);
        bus_in = v; mar_in = 1'b1;
        @(negedge clk);
        mar_in = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        bus_in = v; mdr_in = 1'b1;
        @(negedge clk);
        mdr_in = 1'b0;
    endtask

    // Issue a request and count negedges until done; finishes back in IDLE
    task automatic main_req(input logic rd, input logic wr, input int exp_k, input string tag);
        int k;
        read = rd; write = wr; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin read = 1'b0; write = 1'b0; end
        end while (!done && k < 40);
        check(tag, 32'(k), 32'(exp_k));
        @(negedge clk);
    endtask

    task automatic aux_read(input int which);
        int k;
        logic dn;
        if (which == 0) a0_read = 1'b1; else a3_read = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin a0_read = 1'b0; a3_read = 1'b0; end
            dn = (which == 0) ? a0_done : a3_done;
        end while (!dn && k < 40);
        if (which == 0) begin
            check("ws0_latency", 32'(k), 32'd2);
            check("ws0_mdr", a0_mdr, AUX0_DATA);
        end else begin
            check("ws3_latency", 32'(k), 32'd5);
            check("ws3_mdr", a3_mdr, AUX3_DATA);
        end
        @(negedge clk);
    endtask

    initial begin
        int wc0;
        total = 0; bad = 0; wr_cnt = 0;
        for (int i = 0; i < 512; i++) wvalid[i] = 1'b0;
        clr = 1'b1; bus_in = '0; mar_in = 0; mdr_in = 0; read = 0; write = 0;
        a0_read = 0; a3_read = 0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_mar", 32'(mar_q), 32'd0);
        check("rst_mdr", mdr_q, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        // Reset mid-read
        load_mar(32'd7);
        load_mdr(32'h55);
        sb.push_back(32'hDEAD_DEAD);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check("midrd_busy", 32'(busy), 32'd1);
        sb.delete();
        clr = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_mar", 32'(mar_q), 32'd0);
        check("midrst_mdr", mdr_q, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);

        // Write then read back
        load_mar(32'h0000_0005);
        load_mdr(32'hDEAD_BEEF);
        wc0 = wr_cnt;
        sb.push_back(32'hDEAD_BEEF);
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        check("wr_en_in_wr", 32'(ram_wr_en), 32'd1);
        check("wr_addr", 32'(ram_addr), 32'd5);
        check("wr_data", ram_w_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wr_en_after", 32'(ram_wr_en), 32'd0);
        check("wr_done", 32'(done), 32'd1);
        check("wr_pulses", 32'(wr_cnt - wc0), 32'd1);
        check("ram5", mem[5], 32'hDEAD_BEEF);
        @(negedge clk);
        load_mdr(32'h0);
        check("mdr_cleared", mdr_q, 32'h0);
        sb.push_back(32'hDEAD_BEEF);
        main_req(1'b1, 1'b0, 3, "rd_latency_ws1");

        // Busy lockout during RD_WAIT
        load_mdr(32'h0);
        wc0 = wr_cnt;
        sb.push_back(32'hDEAD_BEEF);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        bus_in = 32'h0000_01FF; mar_in = 1'b1; write = 1'b1;
        @(negedge clk);
        bus_in = 32'h1234_5678; mar_in = 1'b0; mdr_in = 1'b1; write = 1'b1;
        check("lock_mar", 32'(mar_q), 32'd5);
        check("lock_mdr_pre", mdr_q, 32'h0);
        @(negedge clk);
        mdr_in = 1'b0; write = 1'b0;
        check("lock_done", 32'(done), 32'd1);
        check("lock_mdr_cap", mdr_q, 32'hDEAD_BEEF);
        @(negedge clk);
        check("lock_idle", 32'(busy), 32'd0);
        check("lock_mar_after", 32'(mar_q), 32'd5);
        check("lock_no_wr", 32'(wr_cnt - wc0), 32'd0);

        // Simultaneous read and write
        load_mar(32'd9);
        load_mdr(32'h1111_2222);
        wc0 = wr_cnt;
        sb.push_back(32'h1111_2222);
        main_req(1'b1, 1'b1, 2, "rw_latency");
        check("rw_pulses", 32'(wr_cnt - wc0), 32'd1);
        check("rw_ram9", mem[9], 32'h1111_2222);
        check("rw_mdr", mdr_q, 32'h1111_2222);

        // Address truncation, then read an unwritten location
        load_mar(32'hFFFF_FE03);
        check("trunc_mar", 32'(mar_q), 32'h003);
        check("trunc_addr", 32'(ram_addr), 32'h003);
        sb.push_back(32'hA5A5_0003);
        main_req(1'b1, 1'b0, 3, "rd_latency_trunc");

        // Wait-state sweep
        aux_read(0);
        aux_read(3);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory interface stage directly upstream of the 2^DEPTH x WIDTH single-read/single-write RAM.
- Holds the MAR and MDR, accepts read/write requests from the CPU control unit, and drives the RAM address, write data and write-enable.
- Sequences each access with a small FSM and programmable wait states, and returns busy/done to the control unit.

Parameters:
- DEPTH, 9, RAM address width; MAR width.
- WIDTH, 32, data width of bus, MDR and RAM word.
- WAIT_STATES, 1, extra cycles between read start and MDR capture (0..15 legal).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- bus_in  in  WIDTH  datapath bus value.
- mar_in  in  1  load MAR from bus_in[DEPTH-1:0].
- mdr_in  in  1  load MDR from bus_in.
- read  in  1  start a read of mem[MAR] into MDR.
- write  in  1  start a write of MDR to mem[MAR].
- mdr_q  out  WIDTH  current MDR contents; the bus driver is external.
- mar_q  out  DEPTH  current MAR contents.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when an access completes.
- ram_addr  out  DEPTH  to RAM r_addr and w_addr; always equals MAR.
- ram_w_data  out  WIDTH  to RAM w_data; always equals MDR.
- ram_wr_en  out  1  to RAM wr_en.
- ram_r_data  in  WIDTH  from RAM r_data; asynchronous read.

Behaviour:
- Reset (clr=1, async): state=IDLE, MAR=0, MDR=0, wait counter=0.
  - Outputs: busy=0, done=0, ram_wr_en=0, mdr_q=0, mar_q=0.
  - ram_wr_en is decoded from state, so asserting clr drops it immediately. A write whose WR cycle is cut by reset is not committed.
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE:
  - mar_in=1 loads MAR; mdr_in=1 loads MDR. Both may load in the same cycle.
  - write=1 goes to WR. Write has priority, so write=read=1 performs the write only.
  - read=1 (write=0) goes to RD_WAIT with cnt=WAIT_STATES.
  - A load and a request in the same cycle are both honoured. The access then uses the newly loaded MAR/MDR values from the next cycle onward.
- RD_WAIT:
  - If cnt==0: MDR<=ram_r_data and go to DONE. Otherwise cnt<=cnt-1.
  - Read latency from the edge that samples read to the cycle with done=1 is WAIT_STATES+2 edges. Example with WAIT_STATES=1: E0 samples read, E1 decrements, E2 captures, done is high E2..E3.
- WR:
  - Exactly one cycle with ram_wr_en=1, ram_addr=MAR, ram_w_data=MDR.
  - The RAM commits at the next edge, which also moves the FSM to DONE. done is high the cycle after WR.
- DONE: done=1 and busy=1 for one cycle, then unconditionally to IDLE. Back-to-back accesses therefore have at least one IDLE cycle between them.
- While busy (RD_WAIT, WR, DONE):
  - mar_in, mdr_in, read and write are all ignored, so MAR and MDR stay stable for the RAM.
  - A request held high through DONE is accepted in the following IDLE cycle.
- Width rules:
  - MAR takes bus_in[DEPTH-1:0]; upper bus bits are discarded.
  - No address range check is needed: MAR values wrap naturally within 2^DEPTH.
- cnt width: 4 bits.

Decomposition:
- Shared package mem_pkg:
  - State enum: IDLE, RD_WAIT, WR, DONE.
  - Default DEPTH/WIDTH constants, shared with the RAM instance.
- One sub-module, ld_reg: a WIDTH-parameterised register with load-enable and async active-high clr. It is instantiated for MAR and MDR, and the load-enable is gated by !busy.
- FSM and wait counter stay in mem_ctrl.

Test Plan:
1. Reset mid-operation.
   - Stimulus: assert clr during RD_WAIT, then release.
   - Required: state IDLE, mdr_q=0, mar_q=0, busy=0, done=0 immediately on clr.
2. Write then read back.
   - Stimulus: mar_in with bus=0x00000005; mdr_in with bus=0xDEADBEEF; write for 1 cycle.
   - Required during write: ram_wr_en=1 for exactly one cycle at addr 5; done pulses one cycle later.
   - Then: mdr_in with bus=0 followed by read. Required: mdr_q=0xDEADBEEF at the done cycle, done 3 edges after read with WAIT_STATES=1.
3. Wait-state sweep.
   - Stimulus: read with WAIT_STATES=0 and with WAIT_STATES=3.
   - Required: done at edge 2 and edge 5 respectively after the read sample.
4. Busy lockout.
   - Stimulus: during RD_WAIT pulse mar_in with bus=0x1FF, mdr_in with bus=0x12345678, and write.
   - Required: mar_q, mdr_q (until capture) and the FSM are unchanged, and no ram_wr_en pulse occurs.
5. Simultaneous read=write=1 in IDLE.
   - Required: write only, meaning one ram_wr_en pulse; MDR is unchanged and done pulses once.
6. Address truncation.
   - Stimulus: mar_in with bus=0xFFFF_FE03.
   - Required: mar_q=0x003 and ram_addr=0x003.
